// File: rtl/dpd_pkg.sv
// rtl/dpd_pkg.sv - shared constants, address map and FSM states for the DPD coefficient controller
package dpd_pkg;

  localparam int NUM_COEF        = 6;
  localparam int PIPE_LAT_DEF    = 6;
  localparam int FRACT_WIDTH_DEF = 12;

  localparam logic [2:0] ADDR_A10_R = 3'd0;
  localparam logic [2:0] ADDR_A10_I = 3'd1;
  localparam logic [2:0] ADDR_A30_R = 3'd2;
  localparam logic [2:0] ADDR_A30_I = 3'd3;
  localparam logic [2:0] ADDR_A50_R = 3'd4;
  localparam logic [2:0] ADDR_A50_I = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Identity bank has a10_r at unity and every other coefficient at zero.
  function automatic logic [31:0] unity(input int fract_width);
    return 32'd1 << fract_width;
  endfunction

endpackage

// File: rtl/dpd_valid_pipe.sv
// rtl/dpd_valid_pipe.sv - PIPE_LAT-deep sample-valid delay line with output blanking
module dpd_valid_pipe
  import dpd_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic clk_368,
  input  logic rst_n,
  input  logic i_valid,
  input  logic i_blank,
  output logic o_valid
);

  logic [PIPE_LAT-1:0] r_pipe;

  always_ff @(posedge clk_368 or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_valid;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_valid = r_pipe[PIPE_LAT-1] && !i_blank;

endmodule

// File: rtl/dpd_coeff_ctrl.sv
// rtl/dpd_coeff_ctrl.sv - shadow/active coefficient banks with sample-aligned swap for the DPD datapath
// Optional DPD_SWAP_BLANK_EN: forces out_valid low while SETTLE drains samples that straddle a swap.
module dpd_coeff_ctrl
  import dpd_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = FRACT_WIDTH_DEF,
  parameter int PIPE_LAT    = PIPE_LAT_DEF,
  parameter int VER_WIDTH   = 8
) (
  input  logic                  clk_368,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  commit,
  output logic                  commit_ack,
  output logic                  busy,
  input  logic                  bypass,
  input  logic                  in_valid,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] a10_r_o,
  output logic [DATA_WIDTH-1:0] a10_i_o,
  output logic [DATA_WIDTH-1:0] a30_r_o,
  output logic [DATA_WIDTH-1:0] a30_i_o,
  output logic [DATA_WIDTH-1:0] a50_r_o,
  output logic [DATA_WIDTH-1:0] a50_i_o,
  output logic [VER_WIDTH-1:0]  bank_ver,
  output logic                  err_addr
);

  localparam logic [DATA_WIDTH-1:0] UNITY = DATA_WIDTH'(unity(FRACT_WIDTH));
  localparam int                    CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shadow [NUM_COEF];
  logic [DATA_WIDTH-1:0] r_active [NUM_COEF];
  logic [DATA_WIDTH-1:0] r_coef   [NUM_COEF];
  logic [VER_WIDTH-1:0]  r_bank_ver;
  logic                  r_commit_ack;
  logic                  r_err_addr;
  logic                  w_wr_fire;
  logic                  w_addr_ok;
  logic                  w_swap;
  logic                  w_blank;

  assign wr_ready  = (r_state != PEND);
  assign w_wr_fire = wr_valid && wr_ready;
  assign w_addr_ok = (wr_addr <= ADDR_A50_I);
  // The sample presented on the swap cycle still sees the old bank at the outputs.
  assign w_swap    = (r_state == PEND) && in_valid;

  always_ff @(posedge clk_368 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (commit)        w_state_nxt = PEND;
      PEND:    if (in_valid)      w_state_nxt = SETTLE;
      SETTLE:  if (r_cnt == '0)   w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_368 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_swap) begin
      r_cnt <= CNT_W'(PIPE_LAT - 1);
    end else if ((r_state == SETTLE) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_368 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_COEF; i++) begin
        if (w_wr_fire && w_addr_ok && (wr_addr == 3'(i))) begin
          r_shadow[i] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk_368 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        r_active[i] <= '0;
      end
      r_active[ADDR_A10_R] <= UNITY;
    end else if (w_swap) begin
      r_active <= r_shadow;
    end
  end

  // Bypass only steers the outputs; the active bank keeps tracking swaps underneath.
  always_ff @(posedge clk_368 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        r_coef[i] <= '0;
      end
      r_coef[ADDR_A10_R] <= UNITY;
    end else if (bypass) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        r_coef[i] <= '0;
      end
      r_coef[ADDR_A10_R] <= UNITY;
    end else begin
      r_coef <= r_active;
    end
  end

  always_ff @(posedge clk_368 or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_ver   <= '0;
      r_commit_ack <= 1'b0;
      r_err_addr   <= 1'b0;
    end else begin
      r_commit_ack <= w_swap;
      if (w_swap) begin
        r_bank_ver <= r_bank_ver + 1'b1;
      end
      if (w_wr_fire && !w_addr_ok) begin
        r_err_addr <= 1'b1;
      end
    end
  end

`ifdef DPD_SWAP_BLANK_EN
  assign w_blank = (r_state == SETTLE);
`else
  assign w_blank = 1'b0;
`endif

  dpd_valid_pipe #(
    .PIPE_LAT (PIPE_LAT)
  ) u_valid_pipe (
    .clk_368 (clk_368),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .i_blank (w_blank),
    .o_valid (out_valid)
  );

  assign busy       = (r_state != IDLE);
  assign commit_ack = r_commit_ack;
  assign bank_ver   = r_bank_ver;
  assign err_addr   = r_err_addr;
  assign a10_r_o    = r_coef[ADDR_A10_R];
  assign a10_i_o    = r_coef[ADDR_A10_I];
  assign a30_r_o    = r_coef[ADDR_A30_R];
  assign a30_i_o    = r_coef[ADDR_A30_I];
  assign a50_r_o    = r_coef[ADDR_A50_R];
  assign a50_i_o    = r_coef[ADDR_A50_I];

endmodule
